// File: rtl/parity_stream_if.sv
// Valid/ready word-stream link for parity_stream_chk: the producer and consumer handshakes plus frame summary outputs.
// master = producer/consumer side, slave = the checker.
interface parity_stream_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par;
    logic              out_err;
    logic              out_last;
    logic              frm_par;
    logic [LEN_W-1:0]  frm_len;
    logic              frm_err;

    modport master (
        output in_valid, in_data, in_par, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_par, out_err, out_last,
               frm_par, frm_len, frm_err
    );

    modport slave (
        input  in_valid, in_data, in_par, in_last, out_ready,
        output in_ready, out_valid, out_data, out_par, out_err, out_last,
               frm_par, frm_len, frm_err
    );
endinterface

// File: rtl/parity_stream_chk.sv
// Pipelined odd/even parity generator/checker for a framed valid/ready word stream, with per-frame summary.
// Optional macro PARITY_ERR_INJECT_EN adds err_inj, which inverts out_par on the accepted beat.
module parity_stream_chk #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b1,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    parity_stream_if.slave   bus,
    input  logic             clr_cnt,
`ifdef PARITY_ERR_INJECT_EN
    input  logic             err_inj,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {IDLE, FRAME} state_t;

    function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic              acc_x_q, acc_x_d;
    logic [LEN_W-1:0]  acc_len_q, acc_len_d;
    logic              acc_err_q, acc_err_d;

    logic              accept_p0;
    logic              xor_p0;
    logic              gen_p0;
    logic              err_p0;
    logic              inj_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              par_p1;
    logic              err_p1;
    logic              last_p1;
    logic              frm_par_p1;
    logic [LEN_W-1:0]  frm_len_p1;
    logic              frm_err_p1;

    // ---- stage p0: input beat, parity generation and frame accumulation ----
    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign accept_p0    = bus.in_valid && bus.in_ready;
    assign xor_p0       = ^bus.in_data;
    assign gen_p0       = xor_p0 ^ ODD;
    assign err_p0       = bus.in_par != gen_p0;

`ifdef PARITY_ERR_INJECT_EN
    assign inj_p0 = err_inj;
`else
    assign inj_p0 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_x_q   <= 1'b0;
            acc_len_q <= '0;
            acc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_x_q   <= acc_x_d;
            acc_len_q <= acc_len_d;
            acc_err_q <= acc_err_d;
        end
    end

    // The *_d values on an accept are the frame totals including the current word,
    // which is exactly what the last beat must report.
    always_comb begin
        state_d   = state_q;
        acc_x_d   = acc_x_q;
        acc_len_d = acc_len_q;
        acc_err_d = acc_err_q;
        if (accept_p0) begin
            case (state_q)
                FRAME: begin
                    acc_x_d   = acc_x_q ^ xor_p0;
                    acc_len_d = sat_inc_len(acc_len_q);
                    acc_err_d = acc_err_q | err_p0;
                    if (bus.in_last) state_d = IDLE;
                end
                default: begin
                    acc_x_d   = xor_p0;
                    acc_len_d = LEN_W'(1);
                    acc_err_d = err_p0;
                    state_d   = bus.in_last ? IDLE : FRAME;
                end
            endcase
        end
    end

    // ---- stage p1: registered output beat ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            par_p1     <= 1'b0;
            err_p1     <= 1'b0;
            last_p1    <= 1'b0;
            frm_par_p1 <= 1'b0;
            frm_len_p1 <= '0;
            frm_err_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1     <= 1'b1;
            data_p1    <= bus.in_data;
            par_p1     <= gen_p0 ^ inj_p0;
            err_p1     <= err_p0;
            last_p1    <= bus.in_last;
            frm_par_p1 <= bus.in_last ? (acc_x_d ^ ODD) : 1'b0;
            frm_len_p1 <= bus.in_last ? acc_len_d : '0;
            frm_err_p1 <= bus.in_last ? acc_err_d : 1'b0;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Clear wins over a coincident error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (accept_p0 && err_p0) begin
            err_cnt <= sat_inc_cnt(err_cnt);
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_par   = par_p1;
    assign bus.out_err   = err_p1;
    assign bus.out_last  = last_p1;
    assign bus.frm_par   = frm_par_p1;
    assign bus.frm_len   = frm_len_p1;
    assign bus.frm_err   = frm_err_p1;

endmodule

// File: tb/tb_parity_stream_chk.sv
// Directed bench for parity_stream_chk: one DUT with a 16-bit error counter, one with a 2-bit counter.
module tb_parity_stream_chk;
    logic        clk;
    logic        rst_n;
    logic        clr_cnt;
    logic        clr_cnt2;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;
    int          errors;
    int          checks;
`ifdef PARITY_ERR_INJECT_EN
    logic        err_inj;
    logic        err_inj2;
`endif

    parity_stream_if #(.DATA_W(8), .LEN_W(8)) b  ();
    parity_stream_if #(.DATA_W(8), .LEN_W(8)) b2 ();

    parity_stream_chk #(.DATA_W(8), .ODD(1'b1), .LEN_W(8), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (b),
        .clr_cnt (clr_cnt),
`ifdef PARITY_ERR_INJECT_EN
        .err_inj (err_inj),
`endif
        .err_cnt (err_cnt)
    );

    parity_stream_chk #(.DATA_W(8), .ODD(1'b1), .LEN_W(8), .CNT_W(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (b2),
        .clr_cnt (clr_cnt2),
`ifdef PARITY_ERR_INJECT_EN
        .err_inj (err_inj2),
`endif
        .err_cnt (err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic [7:0] d, input logic p, input logic l);
        b.in_valid = 1'b1; b.in_data = d; b.in_par = p; b.in_last = l;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
    endtask

    task automatic beat2(input logic [7:0] d, input logic p, input logic l);
        b2.in_valid = 1'b1; b2.in_data = d; b2.in_par = p; b2.in_last = l;
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", b.out_valid); end
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", b.in_ready); end
        checks++; if (b.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", b.out_data); end
        checks++; if (b.frm_len !== 8'h00) begin errors++; $display("FAIL reset_frm_len: got %0d want 0", b.frm_len); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (err_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_err_cnt2: got %0d want 0", err_cnt2); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word;
        beat(8'h00, 1'b1, 1'b1);
        checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL single0_valid: got %b want 1", b.out_valid); end
        checks++; if (b.out_par !== 1'b1) begin errors++; $display("FAIL single0_par: got %b want 1", b.out_par); end
        checks++; if (b.out_err !== 1'b0) begin errors++; $display("FAIL single0_err: got %b want 0", b.out_err); end
        checks++; if (b.frm_len !== 8'd1) begin errors++; $display("FAIL single0_frm_len: got %0d want 1", b.frm_len); end
        checks++; if (b.frm_par !== 1'b1) begin errors++; $display("FAIL single0_frm_par: got %b want 1", b.frm_par); end
        beat(8'h07, 1'b1, 1'b1);
        checks++; if (b.out_data !== 8'h07) begin errors++; $display("FAIL single1_data: got %h want 07", b.out_data); end
        checks++; if (b.out_par !== 1'b0) begin errors++; $display("FAIL single1_par: got %b want 0", b.out_par); end
        checks++; if (b.out_err !== 1'b1) begin errors++; $display("FAIL single1_err: got %b want 1", b.out_err); end
        checks++; if (b.frm_err !== 1'b1) begin errors++; $display("FAIL single1_frm_err: got %b want 1", b.frm_err); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL single1_err_cnt: got %0d want 1", err_cnt); end
        @(posedge clk); #1;
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", b.out_valid); end
    endtask

    task automatic test_frame;
        beat(8'h01, 1'b0, 1'b0);
        checks++; if (b.out_data !== 8'h01 || b.out_par !== 1'b0 || b.out_last !== 1'b0) begin errors++; $display("FAIL frame_w0: got data=%h par=%b last=%b want 01 0 0", b.out_data, b.out_par, b.out_last); end
        checks++; if (b.frm_len !== 8'd0) begin errors++; $display("FAIL frame_w0_frm_len: got %0d want 0", b.frm_len); end
        beat(8'h03, 1'b1, 1'b0);
        checks++; if (b.out_data !== 8'h03 || b.out_par !== 1'b1 || b.out_err !== 1'b0) begin errors++; $display("FAIL frame_w1: got data=%h par=%b err=%b want 03 1 0", b.out_data, b.out_par, b.out_err); end
        beat(8'h00, 1'b1, 1'b1);
        checks++; if (b.out_valid !== 1'b1 || b.out_last !== 1'b1) begin errors++; $display("FAIL frame_w2_last: got valid=%b last=%b want 1 1", b.out_valid, b.out_last); end
        checks++; if (b.frm_par !== 1'b0) begin errors++; $display("FAIL frame_frm_par: got %b want 0", b.frm_par); end
        checks++; if (b.frm_len !== 8'd3) begin errors++; $display("FAIL frame_frm_len: got %0d want 3", b.frm_len); end
        checks++; if (b.frm_err !== 1'b0) begin errors++; $display("FAIL frame_frm_err: got %b want 0", b.frm_err); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL frame_err_cnt: got %0d want 1", err_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        b.in_valid = 1'b1; b.in_data = 8'h10; b.in_par = 1'b0; b.in_last = 1'b0;
        @(posedge clk); #1;
        b.in_data = 8'h20; b.in_par = 1'b0;
        b.out_ready = 1'b0;
        #1;
        checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", b.in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (b.out_valid !== 1'b1 || b.out_data !== 8'h10) begin errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h want 1 10", i, b.out_valid, b.out_data); end
        end
        b.out_ready = 1'b1;
        #1;
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_high: got %b want 1", b.in_ready); end
        @(posedge clk); #1;
        checks++; if (b.out_data !== 8'h20 || b.out_last !== 1'b0) begin errors++; $display("FAIL bp_w1: got data=%h last=%b want 20 0", b.out_data, b.out_last); end
        b.in_data = 8'h30; b.in_par = 1'b1; b.in_last = 1'b1;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        checks++; if (b.out_data !== 8'h30 || b.out_last !== 1'b1) begin errors++; $display("FAIL bp_w2: got data=%h last=%b want 30 1", b.out_data, b.out_last); end
        checks++; if (b.frm_len !== 8'd3) begin errors++; $display("FAIL bp_frm_len: got %0d want 3", b.frm_len); end
        checks++; if (b.frm_par !== 1'b1) begin errors++; $display("FAIL bp_frm_par: got %b want 1", b.frm_par); end
        @(posedge clk); #1;
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", b.out_valid); end
    endtask

    task automatic test_err_saturation;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            beat2(8'h00, 1'b0, 1'b1);
            checks++; if (err_cnt2 !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, err_cnt2, exp_cnt[i]); end
        end
        clr_cnt2 = 1'b1;
        beat2(8'h00, 1'b0, 1'b1);
        clr_cnt2 = 1'b0;
        checks++; if (err_cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clr_priority: got %0d want 0", err_cnt2); end
        beat2(8'h00, 1'b0, 1'b1);
        checks++; if (err_cnt2 !== 2'd1) begin errors++; $display("FAIL sat_after_clr: got %0d want 1", err_cnt2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame;
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h02, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (b.out_valid !== 1'b0 || b.out_data !== 8'h00) begin errors++; $display("FAIL midrst_out: got valid=%b data=%h want 0 00", b.out_valid, b.out_data); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", b.in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(8'hFF, 1'b1, 1'b1);
        checks++; if (b.frm_len !== 8'd1) begin errors++; $display("FAIL midrst_frm_len: got %0d want 1", b.frm_len); end
        checks++; if (b.frm_par !== 1'b1) begin errors++; $display("FAIL midrst_frm_par: got %b want 1", b.frm_par); end
        checks++; if (b.out_err !== 1'b0) begin errors++; $display("FAIL midrst_out_err: got %b want 0", b.out_err); end
        @(posedge clk); #1;
    endtask

`ifdef PARITY_ERR_INJECT_EN
    task automatic test_inject;
        err_inj = 1'b1;
        beat(8'h00, 1'b1, 1'b1);
        err_inj = 1'b0;
        checks++; if (b.out_par !== 1'b0) begin errors++; $display("FAIL inj_par: got %b want 0", b.out_par); end
        checks++; if (b.out_err !== 1'b0) begin errors++; $display("FAIL inj_err: got %b want 0", b.out_err); end
        checks++; if (b.frm_par !== 1'b1) begin errors++; $display("FAIL inj_frm_par: got %b want 1", b.frm_par); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL inj_err_cnt: got %0d want 0", err_cnt); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        errors = 0; checks = 0;
        clk = 1'b0; rst_n = 1'b0; clr_cnt = 1'b0; clr_cnt2 = 1'b0;
        b.in_valid = 1'b0; b.in_data = '0; b.in_par = 1'b0; b.in_last = 1'b0; b.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.in_par = 1'b0; b2.in_last = 1'b0; b2.out_ready = 1'b1;
`ifdef PARITY_ERR_INJECT_EN
        err_inj = 1'b0; err_inj2 = 1'b0;
`endif
        test_reset;
        test_single_word;
        test_frame;
        test_backpressure;
        test_err_saturation;
        test_reset_mid_frame;
`ifdef PARITY_ERR_INJECT_EN
        test_inject;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
